// File: rtl/piradip_cdc_pkg.sv
// rtl/piradip_cdc_pkg.sv - shared types and helpers for the CDC update-capture stage
package piradip_cdc_pkg;

  // Default geometry of the capture FIFO
  localparam int CDC_DEPTH = 4;
  localparam int ADDR_W    = $clog2(CDC_DEPTH);
  // Widest counter the saturating helper supports
  localparam int CNT_MAX_W = 64;

  // Pointers carry one extra wrap bit to tell full from empty
  typedef logic [ADDR_W:0] ptr_t;
  typedef logic [ADDR_W:0] level_t;

  // Increment cnt, holding at the all-ones value of a cnt_w-bit counter
  function automatic logic [CNT_MAX_W-1:0] cdc_cnt_sat_inc(
    input logic [CNT_MAX_W-1:0] cnt,
    input int unsigned          cnt_w
  );
    logic [CNT_MAX_W-1:0] max_v;
    if (cnt_w >= CNT_MAX_W) max_v = '1;
    else                    max_v = (CNT_MAX_W'(1) << cnt_w) - CNT_MAX_W'(1);
    return (cnt >= max_v) ? max_v : cnt + CNT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/piradip_cdc_capture_fifo.sv
// rtl/piradip_cdc_capture_fifo.sv - first-word fall-through FIFO with registered head and overwrite port
module piradip_cdc_capture_fifo
  import piradip_cdc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = CDC_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     dst_clk,
  input  logic                     dst_rstn,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_update,
  input  logic                     ovr_en,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     pop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
  logic [AW-1:0]    newest_addr;
  logic             push, valid_nx;
  logic [WIDTH-1:0] head_nx;

  assign full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop         = out_valid & out_ready;
  assign push        = in_update & (~full | pop);
  assign wr_ptr_nx   = wr_ptr + {{AW{1'b0}}, push};
  assign rd_ptr_nx   = rd_ptr + {{AW{1'b0}}, pop};
  assign valid_nx    = (wr_ptr_nx != rd_ptr_nx);
  assign newest_addr = wr_ptr[AW-1:0] - AW'(1);
  assign level       = wr_ptr - rd_ptr;

  // Next head word: storage at the next read address, bypassing any same-cycle write to it
  always_comb begin
    head_nx = mem[rd_ptr_nx[AW-1:0]];
    if (push && (wr_ptr[AW-1:0] == rd_ptr_nx[AW-1:0])) head_nx = in_data;
    if (ovr_en && (newest_addr == rd_ptr_nx[AW-1:0]))  head_nx = in_data;
  end

  // Storage writes: normal push at wr_ptr, or coalescing overwrite of the newest entry
  always_ff @(posedge dst_clk) begin
    if (push)        mem[wr_ptr[AW-1:0]] <= in_data;
    else if (ovr_en) mem[newest_addr]    <= in_data;
  end

  // Pointers and the registered head presented to the consumer
  always_ff @(posedge dst_clk or negedge dst_rstn) begin
    if (!dst_rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= RESET_VAL;
    end else begin
      wr_ptr    <= wr_ptr_nx;
      rd_ptr    <= rd_ptr_nx;
      out_valid <= valid_nx;
      out_data  <= valid_nx ? head_nx : RESET_VAL;
    end
  end

endmodule

// File: rtl/piradip_cdc_update_capture.sv
// rtl/piradip_cdc_update_capture.sv - captures CDC update pulses into a stream; option PIRADIP_CDC_CAPTURE_COALESCE_EN
module piradip_cdc_update_capture
  import piradip_cdc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 4,
  parameter int               CNT_W     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   dst_clk,
  input  logic                   dst_rstn,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_update,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       last_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_count,
  input  logic                   clear_overflow
);

  logic full, pop, drop, ovr_en;

  // A word is lost (or coalesced) when the FIFO is full and nothing leaves this cycle
  assign drop = in_update & full & ~pop;

`ifdef PIRADIP_CDC_CAPTURE_COALESCE_EN
  assign ovr_en = drop;
`else
  assign ovr_en = 1'b0;
`endif

  piradip_cdc_capture_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (RESET_VAL)
  ) u_fifo (
    .dst_clk   (dst_clk),
    .dst_rstn  (dst_rstn),
    .in_data   (in_data),
    .in_update (in_update),
    .ovr_en    (ovr_en),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .level     (level),
    .full      (full),
    .pop       (pop)
  );

  // Latest delivered word, independent of consumer backpressure
  always_ff @(posedge dst_clk or negedge dst_rstn) begin
    if (!dst_rstn)      last_data <= RESET_VAL;
    else if (in_update) last_data <= in_data;
  end

  // Sticky overflow flag and saturating drop counter; a clear beats a same-cycle drop
  always_ff @(posedge dst_clk or negedge dst_rstn) begin
    if (!dst_rstn) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= CNT_W'(cdc_cnt_sat_inc(CNT_MAX_W'(drop_count), CNT_W));
    end
  end

endmodule

// File: tb/tb_piradip_cdc_update_capture.sv
// tb/tb_piradip_cdc_update_capture.sv - randomized model-checked bench for the update-capture stage
module tb_piradip_cdc_update_capture;

`ifdef PIRADIP_CDC_CAPTURE_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_update = 1'b0;
  logic        out_ready = 1'b0;
  logic        clear_overflow = 1'b0;

  logic [31:0] out_data, last_data, d2_out_data, d2_last_data;
  logic        out_valid, overflow, d2_out_valid, d2_overflow;
  logic [2:0]  level, d2_level;
  logic [15:0] drop_count;
  logic [1:0]  d2_drop_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] q[$];
  logic [31:0] m_last;
  bit          m_ovf;
  int          m_cnt, m_cnt2;

  always #5 clk = ~clk;

  piradip_cdc_update_capture dut (
    .dst_clk(clk), .dst_rstn(rst_n), .in_data(in_data), .in_update(in_update),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .last_data(last_data), .level(level), .overflow(overflow),
    .drop_count(drop_count), .clear_overflow(clear_overflow)
  );

  piradip_cdc_update_capture #(.CNT_W(2)) dut2 (
    .dst_clk(clk), .dst_rstn(rst_n), .in_data(in_data), .in_update(in_update),
    .out_data(d2_out_data), .out_valid(d2_out_valid), .out_ready(out_ready),
    .last_data(d2_last_data), .level(d2_level), .overflow(d2_overflow),
    .drop_count(d2_drop_count), .clear_overflow(clear_overflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model update on every edge, then compare all outputs just after it
  always @(posedge clk or negedge rst_n) begin
    bit pop, full, drop;
    logic [31:0] exp_data;
    if (!rst_n) begin
      q.delete();
      m_last = '0; m_ovf = 0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      pop  = (q.size() > 0) && out_ready;
      full = (q.size() == 4);
      drop = in_update && full && !pop;
      if (pop) void'(q.pop_front());
      if (in_update && !drop) q.push_back(in_data);
      else if (drop && COAL) q[q.size()-1] = in_data;
      if (in_update) m_last = in_data;
      if (clear_overflow) begin
        m_ovf = 0; m_cnt = 0; m_cnt2 = 0;
      end else if (drop) begin
        m_ovf = 1;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    #1;
    exp_data = (q.size() > 0) ? q[0] : 32'h0;
    chk("out_valid",  64'(out_valid),  64'(q.size() > 0));
    chk("out_data",   64'(out_data),   64'(exp_data));
    chk("level",      64'(level),      64'(q.size()));
    chk("last_data",  64'(last_data),  64'(m_last));
    chk("overflow",   64'(overflow),   64'(m_ovf));
    chk("drop_count", 64'(drop_count), 64'(m_cnt));
    chk("d2_valid",   64'(d2_out_valid), 64'(q.size() > 0));
    chk("d2_data",    64'(d2_out_data),  64'(exp_data));
    chk("d2_level",   64'(d2_level),     64'(q.size()));
    chk("d2_last",    64'(d2_last_data), 64'(m_last));
    chk("d2_ovf",     64'(d2_overflow),  64'(m_ovf));
    chk("d2_drops",   64'(d2_drop_count), 64'(m_cnt2));
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(input logic [31:0] d);
    in_update = 1'b1; in_data = d;
    cyc();
    in_update = 1'b0;
  endtask

  task automatic drain(input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] exp_w [4];
    exp_w[0] = e0; exp_w[1] = e1; exp_w[2] = e2; exp_w[3] = e3;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data",  64'(out_data), 64'(exp_w[i]));
      chk("drain_level", 64'(level),    64'(4 - i));
      cyc();
    end
    out_ready = 1'b0;
    chk("drained_level", 64'(level), 64'd0);
  endtask

  initial begin
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(level),     64'd0);
    chk("rst_drops", 64'(drop_count), 64'd0);

    // Single word through an idle FIFO
    out_ready = 1'b1;
    pulse(32'hA5A5_0001);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_data",  64'(out_data),  64'hA5A5_0001);
    cyc();
    chk("single_gone", 64'(out_valid), 64'd0);
    chk("single_last", 64'(last_data), 64'hA5A5_0001);

    // Fill then drain in order
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) pulse(32'(i));
    chk("fill_level", 64'(level),    64'd4);
    chk("fill_ovf",   64'(overflow), 64'd0);
    drain(1, 2, 3, 4);

    // Overflow with two extra words
    for (int i = 1; i <= 6; i++) pulse(32'(i));
    chk("ovf_drops", 64'(drop_count), 64'd2);
    chk("ovf_flag",  64'(overflow),   64'd1);
    chk("ovf_last",  64'(last_data),  64'd6);
    if (COAL) drain(1, 2, 3, 6);
    else      drain(1, 2, 3, 4);
    clear_overflow = 1'b1; cyc(); clear_overflow = 1'b0;
    chk("clr_drops", 64'(drop_count), 64'd0);

    // Full FIFO accepting a push while popping
    for (int i = 1; i <= 4; i++) pulse(32'(i));
    out_ready = 1'b1;
    pulse(32'd5);
    out_ready = 1'b0;
    chk("pp_level", 64'(level),      64'd4);
    chk("pp_drops", 64'(drop_count), 64'd0);
    drain(2, 3, 4, 5);

    // Narrow counter saturation, then clear beating a drop
    for (int i = 1; i <= 4; i++) pulse(32'(i));
    for (int i = 0; i < 5; i++) pulse(32'(10 + i));
    chk("sat_d2",   64'(d2_drop_count), 64'd3);
    chk("sat_wide", 64'(drop_count),    64'd5);
    clear_overflow = 1'b1;
    pulse(32'd20);
    clear_overflow = 1'b0;
    chk("clrdrop_cnt", 64'(drop_count), 64'd0);
    chk("clrdrop_ovf", 64'(overflow),   64'd0);
    if (COAL) drain(1, 2, 3, 20);
    else      drain(1, 2, 3, 4);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      in_update      = ($urandom_range(0, 1) == 1);
      in_data        = $urandom;
      out_ready      = ($urandom_range(0, 2) == 0);
      clear_overflow = ($urandom_range(0, 63) == 0);
      cyc();
    end
    in_update = 1'b0; clear_overflow = 1'b0;

    // Asynchronous reset with three words queued and overflow set
    out_ready = 1'b1;
    repeat (6) cyc();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) pulse(32'(i));
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
    chk("pre_rst_level", 64'(level),    64'd3);
    chk("pre_rst_ovf",   64'(overflow), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_level", 64'(level),     64'd0);
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_data",  64'(out_data),  64'd0);
    chk("arst_last",  64'(last_data), 64'd0);
    chk("arst_ovf",   64'(overflow),  64'd0);
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
